// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | riscv_pkg : load funct3 codes, load-unit state encoding, helpers   |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package riscv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } ld_state_e;

   function automatic logic f3_legal(input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
         default:                             ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      case (f3)
         F3_LH, F3_LHU: mis = off[0];
         F3_LW:         mis = (off != 2'b00);
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_extract : little-endian byte/half/word select with extension  |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module load_extract
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (off)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {24'h000000, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data = {16'h0000, half_sel};
         default: data = rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_unit : stalling load unit, fixed-latency data-memory read     |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module load_unit
   import riscv_pkg::*;
#(
   parameter int LAT = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_req,
   input  logic [2:0]  ld_funct3,
   input  logic [31:0] ld_addr,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] mem_rdata,
   output logic        mem_re,
   output logic [31:0] mem_addr,
   output logic        stall,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        ld_err
);

   localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

   ld_state_e   state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [4:0]  rd_q, rd_d;
   logic        wb_en_q, wb_en_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        ld_err_q, ld_err_d;

   logic        bad;
   logic        accept;
   logic [31:0] ext_data;

   load_extract u_extract (
      .funct3 (funct3_q),
      .off    (off_q),
      .rdata  (mem_rdata),
      .data   (ext_data)
   );

   // rst gates the combinational strobes so they drop the moment reset asserts
   always_comb begin
      bad    = !f3_legal(ld_funct3) || f3_misaligned(ld_funct3, ld_addr[1:0]);
      accept = rst && (state_q == IDLE) && ld_req && !bad;
   end

   assign mem_re   = accept;
   assign mem_addr = accept ? {ld_addr[31:2], 2'b00} : 32'h0000_0000;
   assign stall    = accept ||
                     (rst && (state_q == WAIT) && ((cnt_q != 2'd0) || ld_req));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      funct3_d  = funct3_q;
      off_d     = off_q;
      rd_d      = rd_q;
      wb_en_d   = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      ld_err_d  = (state_q == IDLE) && ld_req && bad;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = WAIT;
               cnt_d    = CNT_INIT;
               funct3_d = ld_funct3;
               off_d    = ld_addr[1:0];
               rd_d     = ld_rd;
            end
         end
         WAIT: begin
            if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else begin
               state_d = IDLE;
               // x0 loads still read memory but leave the writeback port untouched
               if (rd_q != 5'd0) begin
                  wb_en_d   = 1'b1;
                  wb_rd_d   = rd_q;
                  wb_data_d = ext_data;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= 2'd0;
         funct3_q  <= 3'd0;
         off_q     <= 2'd0;
         rd_q      <= 5'd0;
         wb_en_q   <= 1'b0;
         wb_rd_q   <= 5'd0;
         wb_data_q <= 32'h0000_0000;
         ld_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         funct3_q  <= funct3_d;
         off_q     <= off_d;
         rd_q      <= rd_d;
         wb_en_q   <= wb_en_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         ld_err_q  <= ld_err_d;
      end
   end

   assign wb_en   = wb_en_q;
   assign wb_rd   = wb_rd_q;
   assign wb_data = wb_data_q;
   assign ld_err  = ld_err_q;

endmodule
`default_nettype wire

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter LAT, default 1: data-memory read latency in cycles, legal range 1..4.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ld_req  input  1  decoder: current instruction is a load.
REQ-005 ld_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-006 ld_addr  input  32  ALU effective byte address.
REQ-007 ld_rd  input  5  destination register index.
REQ-008 mem_rdata  input  32  data-memory word, valid exactly LAT cycles after the mem_re cycle.
REQ-009 mem_re  output  1  data-memory read strobe.
REQ-010 mem_addr  output  32  word-aligned read address.
REQ-011 stall  output  1  to PC/pipeline; PC holds its value while high.
REQ-012 wb_en, wb_rd, wb_data  output  1/5/32  register-file writeback.
REQ-013 ld_err  output  1  misaligned or illegal load indication.

Function
REQ-014 Two states, IDLE and WAIT, plus a down-counter cnt (2 bits).
REQ-015 Accept = state IDLE and ld_req=1 and funct3 legal and address aligned.
REQ-016 On accept: mem_re=1 (combinational, same cycle); mem_addr={ld_addr[31:2],2'b00}; capture funct3, ld_addr[1:0], ld_rd; cnt<=LAT-1; go to WAIT.
REQ-017 When mem_re=0, mem_addr SHALL be 0; mem_re is high exactly one cycle per accepted load.
REQ-018 stall = (IDLE and accept) or (WAIT and (cnt!=0 or ld_req)); a load therefore stalls exactly LAT cycles.
REQ-019 In WAIT with cnt!=0: cnt decrements.
REQ-020 In WAIT with cnt==0: sample mem_rdata, extract into wb_data, set wb_rd; go to IDLE.
REQ-021 wb_en is a registered one-cycle pulse in the cycle after capture; it is forced 0 when the captured rd==0, but the memory read is still performed.
REQ-022 Extraction, little-endian, off=captured addr[1:0]: LB/LBU take rdata[8*off+7:8*off]; LH/LHU take rdata[16*off[1]+15:16*off[1]]; LW takes the full word.
REQ-023 Extension: LB/LH sign-extend; LBU/LHU zero-extend.
REQ-024 Misaligned: LH/LHU with addr[0]=1; LW with addr[1:0]!=0.
REQ-025 Illegal: funct3 in {011,110,111}.
REQ-026 Misaligned or illegal in IDLE: no mem_re, stall=0, no state change; ld_err pulses one cycle, registered, in the next cycle; no wb_en.
REQ-027 ld_req arriving in WAIT is not accepted; stall holds it, and it is evaluated in IDLE on the following cycle.
REQ-028 wb_data and wb_rd hold their last values when wb_en=0.

Reset
REQ-029 rst low: state IDLE, cnt 0, wb_en 0, wb_rd 0, wb_data 0, ld_err 0, mem_re 0, mem_addr 0, stall 0, all immediately and independent of clk.
REQ-030 Reset in WAIT aborts the load: no wb_en, and mem_rdata is ignored.
REQ-031 The first accept is possible on the first rising edge after rst deasserts.

Structure
REQ-032 Shared package riscv_pkg holds the funct3 load constants and the IDLE/WAIT state encoding.
REQ-033 One combinational sub-module load_extract (inputs funct3, off, rdata; output 32-bit extended data) holds the REQ-022/023 logic.
REQ-034 RTL size target: 120-400 lines.

Verification (mem word at 0x00010100 = 0x808182F3, rd=5)
REQ-035 LAT=1, LW @0x00010100 -> cycle0 mem_re=1, mem_addr=0x00010100, stall=1; cycle1 stall=0; cycle2 wb_en=1, wb_rd=5, wb_data=0x808182F3.
REQ-036 LB @0x00010100 -> 0xFFFFFFF3; LBU @0x00010101 -> 0x00000082; LH @0x00010102 -> 0xFFFF8081; LHU @0x00010102 -> 0x00008081.
REQ-037 LW @0x00010102, and funct3=011 @0x00010100 -> mem_re=0, stall=0, ld_err=1 next cycle, wb_en never 1.
REQ-038 LAT=3, LW, ld_req held high afterwards -> stall high cycles 0-2 and 3; wb_en in cycle 4; second mem_re in cycle 4.
REQ-039 LAT=3, rst pulsed low in cycle 1 -> all outputs 0 immediately; no wb_en afterwards.
REQ-040 LW with rd=0 -> mem_re=1, stall 1 cycle, wb_en stays 0.
